// File: rtl/pic_uart_dump_if.sv
// rtl/pic_uart_dump_if.sv - picture RAM read port and UART byte stream bundle
interface pic_uart_dump_if #(
  parameter int ADDR_W = 17
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              tx_rdy;

  modport master (
    output rd_en, rd_addr, tx_data, tx_vld,
    input  rd_data, tx_rdy
  );

  modport slave (
    input  rd_en, rd_addr, tx_data, tx_vld,
    output rd_data, tx_rdy
  );
endinterface

// File: rtl/pic_uart_dump.sv
// rtl/pic_uart_dump.sv - dumps the picture RAM as lowercase ASCII hex over the UART byte stream
module pic_uart_dump #(
  parameter int PIX_NUM = 129600,
  parameter int ADDR_W  = 17,
  parameter int RD_LAT  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  pic_uart_dump_if.master bus,
  output logic           busy,
  output logic           done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int                WW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WW-1:0]     LAST_WAIT = WW'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_NUM - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_nib;
  logic [23:0]       r_pix;
  logic [WW-1:0]     r_wait;
  logic              r_rd_en;
  logic [7:0]        r_tx_data;
  logic              r_tx_vld;
  logic              r_busy;
  logic              r_done;
  logic              w_hs;

  function automatic logic [7:0] f_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [3:0] f_nib(input logic [23:0] p, input logic [2:0] i);
    case (i)
      3'd0:    return p[23:20];
      3'd1:    return p[19:16];
      3'd2:    return p[15:12];
      3'd3:    return p[11:8];
      3'd4:    return p[7:4];
      default: return p[3:0];
    endcase
  endfunction

  assign w_hs        = r_tx_vld & bus.tx_rdy;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_addr;
  assign bus.tx_data = r_tx_data;
  assign bus.tx_vld  = r_tx_vld;
  assign busy        = r_busy;
  assign done        = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_nib     <= '0;
      r_pix     <= '0;
      r_wait    <= '0;
      r_rd_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (abort && r_state != S_IDLE) begin
      // a handshake in this cycle has already completed on the bus
      r_state  <= S_IDLE;
      r_rd_en  <= 1'b0;
      r_tx_vld <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_rd_en <= 1'b0;
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == LAST_WAIT) begin
            // first character is loaded straight from the RAM word
            r_pix     <= bus.rd_data;
            r_nib     <= 3'd0;
            r_tx_data <= f_ascii(bus.rd_data[23:20]);
            r_tx_vld  <= 1'b1;
            r_state   <= S_SEND;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_nib == 3'd5) begin
              r_tx_vld <= 1'b0;
              r_state  <= S_NEXT;
            end else begin
              r_nib     <= r_nib + 3'd1;
              r_tx_data <= f_ascii(f_nib(r_pix, r_nib + 3'd1));
            end
          end
        end
        S_NEXT: begin
          if (r_addr == LAST_ADDR) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_rd_en <= 1'b1;
            r_state <= S_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_uart_dump.sv
// tb/tb_pic_uart_dump.sv - scoreboard bench for pic_uart_dump (RD_LAT=1 and RD_LAT=3 instances)
module tb_pic_uart_dump;

  logic clk;
  logic rst_n;
  logic start_b, abort_b, busy_b, done_b;
  logic start_c, abort_c, busy_c, done_c;
  logic rdy_b, rdy_c;
  int   mode_b;
  int   total, bad, cyc, ph;

  pic_uart_dump_if #(.ADDR_W(17)) bus_b ();
  pic_uart_dump_if #(.ADDR_W(17)) bus_c ();

  pic_uart_dump #(.PIX_NUM(8), .ADDR_W(17), .RD_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .bus(bus_b), .busy(busy_b), .done(done_b)
  );

  pic_uart_dump #(.PIX_NUM(6), .ADDR_W(17), .RD_LAT(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
    .bus(bus_c), .busy(busy_c), .done(done_c)
  );

  logic [23:0] mem_b [8];
  logic [23:0] mem_c [8];
  logic [23:0] rb_q, rc1, rc2, rc3;
  logic [7:0]  q_b [$];
  logic [7:0]  q_c [$];
  int          hs_b [$];
  int          hs_c [$];
  logic [16:0] addr_b [$];
  logic [16:0] addr_c [$];
  logic [7:0]  exp_b, exp_c, held_b, held_c;
  logic        stall_b, stall_c;

  // RAM models return garbage whenever the read was not issued RD_LAT cycles earlier
  always @(posedge clk) rb_q <= bus_b.rd_en ? mem_b[bus_b.rd_addr[2:0]] : 24'hbad0b0;
  always @(posedge clk) begin
    rc1 <= bus_c.rd_en ? mem_c[bus_c.rd_addr[2:0]] : 24'hbad0c0;
    rc2 <= rc1;
    rc3 <= rc2;
  end
  assign bus_b.rd_data = rb_q;
  assign bus_c.rd_data = rc3;
  assign bus_b.tx_rdy  = rdy_b;
  assign bus_c.tx_rdy  = rdy_c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    rdy_b = 1'b1; rdy_c = 1'b1; ph = 0;
    forever begin
      @(posedge clk); #1;
      ph++;
      rdy_b = (mode_b == 0) || (ph % 3 == 0);
    end
  end

  function automatic logic [7:0] exp_char(input logic [23:0] p, input int i);
    logic [3:0] n;
    n = p[23-4*i -: 4];
    return (n < 4'd10) ? (8'd48 + 8'(n)) : (8'd87 + 8'(n));
  endfunction

  initial begin
    stall_b = 1'b0; held_b = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_b.tx_vld === 1'b1 && bus_b.tx_rdy === 1'b1) begin
        hs_b.push_back(cyc);
        total++;
        if (q_b.size() == 0) begin
          bad++; $display("FAIL char_b: got %h, nothing expected", bus_b.tx_data);
        end else begin
          exp_b = q_b.pop_front();
          if (bus_b.tx_data !== exp_b) begin
            bad++; $display("FAIL char_b: got %h want %h", bus_b.tx_data, exp_b);
          end
        end
      end
      if (stall_b) begin
        total++;
        if (bus_b.tx_vld !== 1'b1 || bus_b.tx_data !== held_b) begin
          bad++; $display("FAIL stall_b: vld=%b data=%h want vld=1 data=%h", bus_b.tx_vld, bus_b.tx_data, held_b);
        end
      end
      stall_b = (bus_b.tx_vld === 1'b1) && (bus_b.tx_rdy !== 1'b1) && (rst_n === 1'b1);
      held_b  = bus_b.tx_data;
      if (bus_b.rd_en === 1'b1) addr_b.push_back(bus_b.rd_addr);
    end
  end

  initial begin
    stall_c = 1'b0; held_c = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_c.tx_vld === 1'b1 && bus_c.tx_rdy === 1'b1) begin
        hs_c.push_back(cyc);
        total++;
        if (q_c.size() == 0) begin
          bad++; $display("FAIL char_c: got %h, nothing expected", bus_c.tx_data);
        end else begin
          exp_c = q_c.pop_front();
          if (bus_c.tx_data !== exp_c) begin
            bad++; $display("FAIL char_c: got %h want %h", bus_c.tx_data, exp_c);
          end
        end
      end
      if (stall_c) begin
        total++;
        if (bus_c.tx_vld !== 1'b1 || bus_c.tx_data !== held_c) begin
          bad++; $display("FAIL stall_c: vld=%b data=%h want vld=1 data=%h", bus_c.tx_vld, bus_c.tx_data, held_c);
        end
      end
      stall_c = (bus_c.tx_vld === 1'b1) && (bus_c.tx_rdy !== 1'b1) && (rst_n === 1'b1);
      held_c  = bus_c.tx_data;
      if (bus_c.rd_en === 1'b1) addr_c.push_back(bus_c.rd_addr);
    end
  end

  task automatic push_b();
    for (int a = 0; a < 8; a++)
      for (int i = 0; i < 6; i++) q_b.push_back(exp_char(mem_b[a], i));
  endtask

  task automatic push_c();
    for (int a = 0; a < 6; a++)
      for (int i = 0; i < 6; i++) q_c.push_back(exp_char(mem_c[a], i));
  endtask

  task automatic pulse_b(output int s);
    @(posedge clk); #1;
    s = cyc; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic pulse_c(output int s);
    @(posedge clk); #1;
    s = cyc; start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_b = 0; abort_b = 0; start_c = 0; abort_c = 0; mode_b = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus_b.rd_en, bus_b.rd_addr, bus_b.tx_data, bus_b.tx_vld, busy_b, done_b} !== '0) begin
      bad++; $display("FAIL reset_b: en=%b addr=%0d data=%h vld=%b busy=%b done=%b, want all 0",
                      bus_b.rd_en, bus_b.rd_addr, bus_b.tx_data, bus_b.tx_vld, busy_b, done_b);
    end
    total++;
    if ({bus_c.rd_en, bus_c.rd_addr, bus_c.tx_data, bus_c.tx_vld, busy_c, done_c} !== '0) begin
      bad++; $display("FAIL reset_c: en=%b addr=%0d data=%h vld=%b busy=%b done=%b, want all 0",
                      bus_c.rd_en, bus_c.rd_addr, bus_c.tx_data, bus_c.tx_vld, busy_c, done_c);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame_b();
    int s, n;
    mem_b[0] = 24'h0A9F3C;
    for (int a = 1; a < 8; a++) mem_b[a] = 24'($urandom);
    push_b(); hs_b.delete(); addr_b.delete();
    pulse_b(s);
    total++;
    if (busy_b !== 1'b1 || bus_b.rd_en !== 1'b1 || bus_b.rd_addr !== 17'd0) begin
      bad++; $display("FAIL frame_start: busy=%b rd_en=%b addr=%0d want 1 1 0", busy_b, bus_b.rd_en, bus_b.rd_addr);
    end
    n = 0;
    while (done_b !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || cyc != s + 73) begin
      bad++; $display("FAIL frame_done: done=%b busy=%b cycle=%0d want 1 0 %0d", done_b, busy_b, cyc - s, 73);
    end
    total++;
    if (hs_b.size() != 48 || q_b.size() != 0) begin
      bad++; $display("FAIL frame_count: chars=%0d left=%0d want 48 0", hs_b.size(), q_b.size());
    end
    for (int k = 0; k < hs_b.size() && k < 48; k++) begin
      total++;
      if (hs_b[k] != s + 3 + 9 * (k / 6) + (k % 6)) begin
        bad++; $display("FAIL frame_timing: char %0d at %0d want %0d", k, hs_b[k] - s, 3 + 9 * (k / 6) + (k % 6));
      end
    end
    total++;
    if (addr_b.size() != 8) begin
      bad++; $display("FAIL frame_reads: reads=%0d want 8", addr_b.size());
    end
    for (int a = 0; a < addr_b.size() && a < 8; a++) begin
      total++;
      if (addr_b[a] !== 17'(a)) begin
        bad++; $display("FAIL frame_addr: read %0d addr=%0d want %0d", a, addr_b[a], a);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus_b.rd_addr !== 17'd7 || done_b !== 1'b1 || bus_b.tx_vld !== 1'b0) begin
      bad++; $display("FAIL frame_hold: addr=%0d done=%b vld=%b want 7 1 0", bus_b.rd_addr, done_b, bus_b.tx_vld);
    end
  endtask

  task automatic test_backpressure_b();
    int s, n;
    for (int a = 0; a < 8; a++) mem_b[a] = (a < 4) ? 24'hFFFFFF : 24'($urandom);
    push_b(); hs_b.delete(); addr_b.delete();
    mode_b = 1;
    pulse_b(s);
    total++;
    if (done_b !== 1'b0 || busy_b !== 1'b1 || bus_b.rd_addr !== 17'd0) begin
      bad++; $display("FAIL restart_from_done: done=%b busy=%b addr=%0d want 0 1 0", done_b, busy_b, bus_b.rd_addr);
    end
    n = 0;
    while (done_b !== 1'b1 && n < 600) begin @(posedge clk); #1; n++; end
    total++;
    if (done_b !== 1'b1 || hs_b.size() != 48 || q_b.size() != 0) begin
      bad++; $display("FAIL bp_count: done=%b chars=%0d left=%0d want 1 48 0", done_b, hs_b.size(), q_b.size());
    end
    mode_b = 0;
  endtask

  task automatic test_start_while_busy_b();
    int s, n;
    for (int a = 0; a < 8; a++) mem_b[a] = 24'($urandom);
    push_b(); hs_b.delete(); addr_b.delete();
    pulse_b(s);
    n = 0;
    while (bus_b.rd_addr !== 17'd3 && n < 100) begin @(posedge clk); #1; n++; end
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    total++;
    if (bus_b.rd_addr === 17'd0 || busy_b !== 1'b1) begin
      bad++; $display("FAIL busy_start: addr=%0d busy=%b want addr!=0 busy=1", bus_b.rd_addr, busy_b);
    end
    n = 0;
    while (done_b !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (done_b !== 1'b1 || cyc != s + 73 || addr_b.size() != 8 || q_b.size() != 0) begin
      bad++; $display("FAIL busy_frame: done=%b cycle=%0d reads=%0d left=%0d want 1 73 8 0",
                      done_b, cyc - s, addr_b.size(), q_b.size());
    end
  endtask

  task automatic test_rdlat3_c();
    int s, n;
    for (int a = 0; a < 6; a++) mem_c[a] = 24'($urandom);
    push_c(); hs_c.delete(); addr_c.delete();
    pulse_c(s);
    n = 0;
    while (done_c !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (done_c !== 1'b1 || busy_c !== 1'b0 || cyc != s + 67) begin
      bad++; $display("FAIL lat3_done: done=%b busy=%b cycle=%0d want 1 0 67", done_c, busy_c, cyc - s);
    end
    total++;
    if (hs_c.size() != 36 || q_c.size() != 0 || addr_c.size() != 6) begin
      bad++; $display("FAIL lat3_count: chars=%0d left=%0d reads=%0d want 36 0 6", hs_c.size(), q_c.size(), addr_c.size());
    end
    for (int k = 0; k < hs_c.size() && k < 36; k++) begin
      total++;
      if (hs_c[k] != s + 5 + 11 * (k / 6) + (k % 6)) begin
        bad++; $display("FAIL lat3_timing: char %0d at %0d want %0d", k, hs_c[k] - s, 5 + 11 * (k / 6) + (k % 6));
      end
    end
  endtask

  task automatic test_abort_c();
    int s, n;
    for (int a = 0; a < 6; a++) mem_c[a] = 24'($urandom);
    push_c(); hs_c.delete();
    pulse_c(s);
    n = 0;
    while (!(hs_c.size() == 26 && bus_c.tx_vld === 1'b1) && n < 400) begin @(posedge clk); #1; n++; end
    abort_c = 1'b1;
    @(posedge clk); #1;
    abort_c = 1'b0;
    total++;
    if (bus_c.tx_vld !== 1'b0 || bus_c.rd_en !== 1'b0 || busy_c !== 1'b0 || done_c !== 1'b0) begin
      bad++; $display("FAIL abort_state: vld=%b rd_en=%b busy=%b done=%b want 0 0 0 0",
                      bus_c.tx_vld, bus_c.rd_en, busy_c, done_c);
    end
    total++;
    if (hs_c.size() != 27 || q_c.size() != 9) begin
      bad++; $display("FAIL abort_sent: chars=%0d left=%0d want 27 9", hs_c.size(), q_c.size());
    end
    q_c.delete();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus_c.tx_vld !== 1'b0 || busy_c !== 1'b0 || bus_c.rd_en !== 1'b0) begin
      bad++; $display("FAIL abort_idle: vld=%b busy=%b rd_en=%b want 0 0 0", bus_c.tx_vld, busy_c, bus_c.rd_en);
    end
    push_c(); hs_c.delete();
    pulse_c(s);
    total++;
    if (bus_c.rd_addr !== 17'd0 || bus_c.rd_en !== 1'b1 || busy_c !== 1'b1) begin
      bad++; $display("FAIL abort_restart: addr=%0d rd_en=%b busy=%b want 0 1 1", bus_c.rd_addr, bus_c.rd_en, busy_c);
    end
    n = 0;
    while (done_c !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (done_c !== 1'b1 || hs_c.size() != 36 || q_c.size() != 0) begin
      bad++; $display("FAIL abort_refill: done=%b chars=%0d left=%0d want 1 36 0", done_c, hs_c.size(), q_c.size());
    end
  endtask

  task automatic test_reset_mid_b();
    int s;
    for (int a = 0; a < 8; a++) mem_b[a] = 24'($urandom);
    push_b();
    pulse_b(s);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus_b.rd_en, bus_b.rd_addr, bus_b.tx_data, bus_b.tx_vld, busy_b, done_b} !== '0) begin
      bad++; $display("FAIL reset_mid: en=%b addr=%0d data=%h vld=%b busy=%b done=%b, want all 0",
                      bus_b.rd_en, bus_b.rd_addr, bus_b.tx_data, bus_b.tx_vld, busy_b, done_b);
    end
    q_b.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus_b.tx_vld !== 1'b0 || busy_b !== 1'b0 || bus_b.rd_addr !== 17'd0) begin
      bad++; $display("FAIL reset_mid_after: vld=%b busy=%b addr=%0d want 0 0 0", bus_b.tx_vld, busy_b, bus_b.rd_addr);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_frame_b();
    test_backpressure_b();
    test_start_while_busy_b();
    test_rdlat3_c();
    test_abort_c();
    test_reset_mid_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
